fft_sample_loader: RTL and testbench

- Input stage directly upstream of the first FFT butterfly stage (FFT_state1).
- Captures one frame of N real 18-bit samples and writes each into the shared complex sample RAM at its bit-reversed address, with the imaginary part set to zero.
- Pulses `start` to the butterfly stage, then holds off until the FFT reports done.
- Supports single-shot (arm) and continuous capture, and counts samples dropped while the FFT is busy.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_bitrev.sv | 14 +
 rtl/fft_sample_loader.sv | 101 ++++++++++
 tb/tb_fft_sample_loader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT chain: default geometry and the one-hot
// stage state encoding used by the loader and the butterfly stages.
package fft_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 18;
    localparam int unsigned N_DEF      = 1 << ADDR_W_DEF;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        CAPTURE  = 4'b0010,
        HANDOFF  = 4'b0100,
        WAIT_FFT = 4'b1000
    } fft_state_e;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational bit-order reversal of an ADDR_W-bit address; also used by the
// output-reorder stage.
module fft_bitrev #(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] o_addr
);

    for (genvar g = 0; g < ADDR_W; g++) begin : g_rev
        assign o_addr[g] = i_addr[ADDR_W-1-g];
    end

endmodule

// File: rtl/fft_sample_loader.sv
// Captures one frame of real samples into the complex sample RAM at
// bit-reversed addresses, hands the frame to the butterfly stage, and waits.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter bit OFFSET_BINARY = 1'b0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              continuous,
    input  logic              sampleValid,
    input  logic [DATA_W-1:0] sampleData,
    input  logic              fftDone,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramDR,
    output logic [DATA_W-1:0] ramDI,
    output logic              ramWe,
    output logic              start,
    output logic              capturing,
    output logic [7:0]        frameCount,
    output logic [15:0]       dropCount
);

    fft_state_e        r_state;
    fft_state_e        w_next;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] w_rev;
    logic [DATA_W-1:0] w_conv;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_dr;
    logic              r_ram_we;
    logic              r_start;
    logic              r_capturing;
    logic [7:0]        r_frame;
    logic [15:0]       r_drop;
    logic              w_accept;

    fft_bitrev #(.ADDR_W(ADDR_W)) u_bitrev (
        .i_addr (r_count),
        .o_addr (w_rev)
    );

    assign w_conv   = OFFSET_BINARY ? {~sampleData[DATA_W-1], sampleData[DATA_W-2:0]}
                                    : sampleData;
    assign w_accept = (r_state == CAPTURE) && sampleValid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (arm) w_next = CAPTURE;
            CAPTURE:  if (w_accept && (r_count == '1)) w_next = HANDOFF;
            HANDOFF:  w_next = WAIT_FFT;
            WAIT_FFT: if (fftDone) w_next = continuous ? CAPTURE : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // start is issued from HANDOFF one cycle later, so it trails the last write.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_ram_addr  <= '0;
            r_ram_dr    <= '0;
            r_ram_we    <= 1'b0;
            r_start     <= 1'b0;
            r_capturing <= 1'b0;
            r_frame     <= '0;
            r_drop      <= '0;
        end else begin
            r_state     <= w_next;
            r_ram_we    <= w_accept;
            r_start     <= (r_state == HANDOFF);
            r_capturing <= (w_next == CAPTURE);
            if (w_accept) begin
                r_ram_addr <= w_rev;
                r_ram_dr   <= w_conv;
                r_count    <= r_count + ADDR_W'(1);
            end else if (r_state != CAPTURE) begin
                r_count <= '0;
            end
            if (r_state == HANDOFF)
                r_frame <= r_frame + 8'd1;
            if ((r_state == WAIT_FFT) && sampleValid && (r_drop != '1))
                r_drop <= r_drop + 16'd1;
        end
    end

    assign ramAddr    = r_ram_addr;
    assign ramDR      = r_ram_dr;
    assign ramDI      = '0;
    assign ramWe      = r_ram_we;
    assign start      = r_start;
    assign capturing  = r_capturing;
    assign frameCount = r_frame;
    assign dropCount  = r_drop;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader at ADDR_W = 3, with a pass-through and
// an offset-binary instance driven from the same stimulus.
module tb_fft_sample_loader;

    localparam int AW = 3;
    localparam int DW = 18;

    logic          Clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          continuous = 1'b0;
    logic          sampleValid = 1'b0;
    logic [DW-1:0] sampleData = '0;
    logic          fftDone = 1'b0;

    logic [AW-1:0] ramAddr0, ramAddr1;
    logic [DW-1:0] ramDR0, ramDR1, ramDI0, ramDI1;
    logic          ramWe0, ramWe1, start0, start1, capt0, capt1;
    logic [7:0]    frame0, frame1;
    logic [15:0]   drop0, drop1;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] exp_addr [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    logic [DW-1:0] ob_data  [8] = '{18'h20000, 18'h00000, 18'h1FFFF, 18'h3FFFF,
                                    18'h00001, 18'h2A5A5, 18'h15A5A, 18'h00007};

    always #5 Clk = ~Clk;

    fft_sample_loader #(.ADDR_W(AW), .DATA_W(DW), .OFFSET_BINARY(1'b0)) dut0 (
        .Clk(Clk), .reset(reset), .arm(arm), .continuous(continuous),
        .sampleValid(sampleValid), .sampleData(sampleData), .fftDone(fftDone),
        .ramAddr(ramAddr0), .ramDR(ramDR0), .ramDI(ramDI0), .ramWe(ramWe0),
        .start(start0), .capturing(capt0), .frameCount(frame0), .dropCount(drop0)
    );

    fft_sample_loader #(.ADDR_W(AW), .DATA_W(DW), .OFFSET_BINARY(1'b1)) dut1 (
        .Clk(Clk), .reset(reset), .arm(arm), .continuous(continuous),
        .sampleValid(sampleValid), .sampleData(sampleData), .fftDone(fftDone),
        .ramAddr(ramAddr1), .ramDR(ramDR1), .ramDI(ramDI1), .ramWe(ramWe1),
        .start(start1), .capturing(capt1), .frameCount(frame1), .dropCount(drop1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic a,
                       input logic f, input logic c);
        sampleValid = v;
        sampleData  = d;
        arm         = a;
        fftDone     = f;
        continuous  = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_write(input int i, input logic [DW-1:0] d);
        chk($sformatf("we[%0d]", i),    32'(ramWe0), 32'd1);
        chk($sformatf("addr[%0d]", i),  32'(ramAddr0), 32'(exp_addr[i]));
        chk($sformatf("dr[%0d]", i),    32'(ramDR0), 32'(d));
        chk($sformatf("di[%0d]", i),    32'(ramDI0), 32'd0);
        chk($sformatf("dr_ob[%0d]", i), 32'(ramDR1), 32'(d ^ 18'h20000));
        chk($sformatf("we_ob[%0d]", i), 32'(ramWe1), 32'd1);
        chk($sformatf("st_cap[%0d]", i), 32'(start0), 32'd0);
    endtask

    initial begin
        // Reset state
        @(posedge Clk); @(posedge Clk); #1;
        chk("rst_we",    32'(ramWe0), 32'd0);
        chk("rst_addr",  32'(ramAddr0), 32'd0);
        chk("rst_dr",    32'(ramDR0), 32'd0);
        chk("rst_di",    32'(ramDI0), 32'd0);
        chk("rst_start", 32'(start0), 32'd0);
        chk("rst_capt",  32'(capt0), 32'd0);
        chk("rst_frame", 32'(frame0), 32'd0);
        chk("rst_drop",  32'(drop0), 32'd0);
        reset = 1'b0;

        // Valid in IDLE is neither written nor dropped
        cyc(1'b1, 18'd5, 1'b0, 1'b0, 1'b0);
        chk("idle_we",   32'(ramWe0), 32'd0);
        chk("idle_drop", 32'(drop0), 32'd0);
        chk("idle_capt", 32'(capt0), 32'd0);

        // Frame 1: back-to-back samples 0..7
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("f1_capt", 32'(capt0), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            chk_write(i, DW'(i));
        end
        chk("f1_capt_end", 32'(capt0), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("f1_start", 32'(start0), 32'd1);
        chk("f1_we0",   32'(ramWe0), 32'd0);
        chk("f1_frame", 32'(frame0), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("f1_start_off", 32'(start0), 32'd0);

        // Drops while waiting: 5 plain, then one coincident with fftDone
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, DW'(100 + i), (i == 0), 1'b0, 1'b0);
            chk($sformatf("wait_we[%0d]", i), 32'(ramWe0), 32'd0);
        end
        chk("drop5", 32'(drop0), 32'd5);
        chk("wait_capt", 32'(capt0), 32'd0);
        cyc(1'b1, 18'd200, 1'b0, 1'b1, 1'b0);
        chk("drop6", 32'(drop0), 32'd6);
        chk("done_capt", 32'(capt0), 32'd0);
        cyc(1'b1, 18'd201, 1'b0, 1'b0, 1'b0);
        chk("idle_drop6", 32'(drop0), 32'd6);
        chk("idle_we2",   32'(ramWe0), 32'd0);

        // Frame 2: a valid every third cycle; stray fftDone during capture
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("f2_capt", 32'(capt0), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, DW'(20 + i), 1'b0, 1'b0, 1'b0);
            chk_write(i, DW'(20 + i));
            cyc(1'b0, '0, 1'b0, (i == 2), 1'b0);
            chk($sformatf("f2_gap_we[%0d]", i), 32'(ramWe0), 32'd0);
            chk($sformatf("f2_gap_st[%0d]", i), 32'(start0), 32'(i == 7));
            if (i == 2) chk("f2_done_ignored", 32'(capt0), 32'd1);
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("f2_gap2_st[%0d]", i), 32'(start0), 32'd0);
        end
        chk("f2_frame", 32'(frame0), 32'd2);

        // Continuous re-entry, frame 3 with offset-binary boundary codes
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("cont_capt", 32'(capt0), 32'd1);
        chk("cont_drop", 32'(drop0), 32'd6);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, ob_data[i], 1'b0, 1'b0, 1'b1);
            chk_write(i, ob_data[i]);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("f3_start", 32'(start0), 32'd1);
        chk("f3_frame", 32'(frame0), 32'd3);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("f3_idle_capt", 32'(capt0), 32'd0);

        // Reset in the middle of frame 4
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, DW'(40 + i), 1'b0, 1'b0, 1'b0);
            chk_write(i, DW'(40 + i));
        end
        #2;
        reset = 1'b1;
        #1;
        chk("mr_we",    32'(ramWe0), 32'd0);
        chk("mr_addr",  32'(ramAddr0), 32'd0);
        chk("mr_dr",    32'(ramDR0), 32'd0);
        chk("mr_capt",  32'(capt0), 32'd0);
        chk("mr_frame", 32'(frame0), 32'd0);
        chk("mr_drop",  32'(drop0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, DW'(50 + i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("mr_start[%0d]", i), 32'(start0), 32'd0);
        end
        reset = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("mr_idle_start", 32'(start0), 32'd0);

        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, DW'(60 + i), 1'b0, 1'b0, 1'b0);
            chk_write(i, DW'(60 + i));
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("f5_start", 32'(start0), 32'd1);
        chk("f5_frame", 32'(frame0), 32'd1);
        chk("f5_frame_ob", 32'(frame1), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("f5_start_off", 32'(start0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
